// File: rtl/ia_packet_loader_if.sv
// Bus bundle for ia_packet_loader: UART byte strobe in, committed register bank and status out.
// The slave modport is the loader's view; the master modport is the byte source / bank consumer.
interface ia_packet_loader_if #(
    parameter int NUM_WORDS = 27,
    parameter int WORD_W    = 16
);
    logic [7:0]                  rx_data;
    logic                        rx_valid;
    logic [NUM_WORDS*WORD_W-1:0] words_out;
    logic                        pc_data_ready;
    logic                        busy;
    logic                        err_checksum;
    logic                        err_timeout;
    logic [7:0]                  frame_count;

    modport master (
        output rx_data,
        output rx_valid,
        input  words_out,
        input  pc_data_ready,
        input  busy,
        input  err_checksum,
        input  err_timeout,
        input  frame_count
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output words_out,
        output pc_data_ready,
        output busy,
        output err_checksum,
        output err_timeout,
        output frame_count
    );
endinterface

// File: rtl/ia_packet_loader.sv
// Sync-framed byte-to-word loader with atomic commit into the vertex-shader register bank.
// Optional trailing XOR checksum byte is enabled by defining IA_CHECKSUM_EN.
//
// state   | meaning
// S_IDLE  | discard bytes until SYNC_BYTE
// S_LOAD  | assemble payload bytes into the shadow buffer
// S_CHECK | compare the trailing byte with the running XOR (IA_CHECKSUM_EN only)
module ia_packet_loader #(
    parameter int         NUM_WORDS   = 27,
    parameter int         WORD_W      = 16,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 50000
) (
    input logic             clk,
    input logic             reset,
    ia_packet_loader_if.slave bus
);
    localparam int BPW         = WORD_W / 8;
    localparam int TOTAL_BYTES = NUM_WORDS * BPW;
    localparam int DATA_W      = NUM_WORDS * WORD_W;
    localparam int CNT_W       = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;
    localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);

`ifdef IA_CHECKSUM_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CHECK = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [TO_W-1:0]     to_q;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [DATA_W-1:0]   words_q;
    logic [7:0]          frame_cnt_q;
    logic                ready_q, busy_q, err_to_q;

    logic                clear_frame, load_byte, commit, timeout;
    logic                last_byte, to_expire;

`ifdef IA_CHECKSUM_EN
    logic [7:0]          xor_q;
    logic                reject;
    logic                err_cks_q;
`endif

    assign last_byte = (cnt_q == CNT_W'(TOTAL_BYTES - 1));
    // Expires on the idle cycle that would bring the count to TIMEOUT_CYC.
    assign to_expire = (to_q == TO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        clear_frame = 1'b0;
        load_byte   = 1'b0;
        commit      = 1'b0;
        timeout     = 1'b0;
`ifdef IA_CHECKSUM_EN
        reject      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                    clear_frame = 1'b1;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.rx_valid) begin
                    load_byte = 1'b1;
                    if (last_byte) begin
`ifdef IA_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        commit  = 1'b1;
                        state_d = S_IDLE;
`endif
                    end
                end else if (to_expire) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
`ifdef IA_CHECKSUM_EN
            S_CHECK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == xor_q) begin
                        commit = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                    state_d = S_IDLE;
                end else if (to_expire) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Byte cnt lands at bit cnt*8: word cnt/BPW, lane cnt%BPW, LSB first.
    always_comb begin
        shadow_d = shadow_q;
        if (load_byte) begin
            for (int i = 0; i < TOTAL_BYTES; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    shadow_d[i*8 +: 8] = bus.rx_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            to_q        <= '0;
            shadow_q    <= '0;
            words_q     <= '0;
            frame_cnt_q <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;

            if (clear_frame) begin
                cnt_q <= '0;
            end else if (load_byte) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if ((state_q == S_IDLE) || bus.rx_valid || timeout) begin
                to_q <= '0;
            end else begin
                to_q <= to_q + 1'b1;
            end

            if (commit) begin
                words_q     <= shadow_d;
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end

            ready_q  <= commit;
            err_to_q <= timeout;
            busy_q   <= (state_d != S_IDLE);
        end
    end

`ifdef IA_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            xor_q     <= '0;
            err_cks_q <= 1'b0;
        end else begin
            if (clear_frame) begin
                xor_q <= '0;
            end else if (load_byte) begin
                xor_q <= xor_q ^ bus.rx_data;
            end
            err_cks_q <= reject;
        end
    end

    assign bus.err_checksum = err_cks_q;
`else
    assign bus.err_checksum = 1'b0;
`endif

    assign bus.words_out     = words_q;
    assign bus.pc_data_ready = ready_q;
    assign bus.busy          = busy_q;
    assign bus.err_timeout   = err_to_q;
    assign bus.frame_count   = frame_cnt_q;
endmodule

// File: tb/tb_ia_packet_loader.sv
// Scoreboard bench for ia_packet_loader: NUM_WORDS=2, WORD_W=16, TIMEOUT_CYC=100.
// Frames carry the trailing XOR byte only when IA_CHECKSUM_EN is defined.
module tb_ia_packet_loader;
    localparam int NW = 2;
    localparam int WW = 16;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic reset = 1'b1;

    ia_packet_loader_if #(.NUM_WORDS(NW), .WORD_W(WW)) bus();

    ia_packet_loader #(
        .NUM_WORDS  (NW),
        .WORD_W     (WW),
        .SYNC_BYTE  (8'hA5),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bank;
        logic [7:0]  fc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          n_ready = 0;
    int          n_cks = 0;
    int          n_to = 0;
    logic [31:0] exp_bank = '0;
    logic [7:0]  exp_fc = '0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.pc_data_ready) begin
            exp_t e;
            n_ready++;
            check_val("commit_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_val("sb_words_out", 64'(bus.words_out), 64'(e.bank));
                check_val("sb_frame_count", 64'(bus.frame_count), 64'(e.fc));
            end
        end
        if (bus.err_checksum) n_cks++;
        if (bus.err_timeout)  n_to++;
    end

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    // Payload p is little endian: byte i = p[i*8 +: 8]; p is also the expected bank.
    task automatic send_frame(input logic [31:0] p, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        bit         expect_commit;
        x = 8'h00;
`ifdef IA_CHECKSUM_EN
        expect_commit = !corrupt;
`else
        expect_commit = 1'b1;
`endif
        if (expect_commit) begin
            exp_fc   = exp_fc + 8'd1;
            exp_bank = p;
            sb.push_back('{bank: p, fc: exp_fc});
        end
        send_byte(8'hA5);
        check_val("busy_after_sync", 64'(bus.busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            b = p[i*8 +: 8];
            x = x ^ b;
            send_byte(b);
        end
`ifdef IA_CHECKSUM_EN
        send_byte(corrupt ? (x ^ 8'h01) : x);
`endif
        check_val("busy_after_frame", 64'(bus.busy), 64'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check_val({tag, "_words"}, 64'(bus.words_out), 64'(exp_bank));
        check_val({tag, "_fc"}, 64'(bus.frame_count), 64'(exp_fc));
        check_val({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    int r0, c0, t0;

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        idle(3);
        check_val("rst_words", 64'(bus.words_out), 64'd0);
        check_val("rst_fc", 64'(bus.frame_count), 64'd0);
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_ready", 64'(bus.pc_data_ready), 64'd0);
        reset = 1'b0;
        idle(2);

        // good frame
        r0 = n_ready;
        send_frame(32'h5678_1234, 1'b0);
        idle(3);
        check_val("s1_ready_cnt", 64'(n_ready - r0), 64'd1);
        check_state("s1");

`ifdef IA_CHECKSUM_EN
        // bad checksum keeps the previous bank
        r0 = n_ready;
        c0 = n_cks;
        send_frame(32'hCAFE_0001, 1'b1);
        idle(3);
        check_val("s2_ready_cnt", 64'(n_ready - r0), 64'd0);
        check_val("s2_cks_cnt", 64'(n_cks - c0), 64'd1);
        check_state("s2");
`endif

        // garbage before sync, then A5 inside the frame is data
        r0 = n_ready;
        send_byte(8'h00);
        send_byte(8'hFF);
        check_val("s3_busy_garbage", 64'(bus.busy), 64'd0);
        send_frame(32'h0000_00A5, 1'b0);
        idle(3);
        check_val("s3_ready_cnt", 64'(n_ready - r0), 64'd1);
        check_state("s3");

        // timeout after a partial frame
        t0 = n_to;
        r0 = n_ready;
        send_byte(8'hA5);
        send_byte(8'h34);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (k == TO - 1) begin
                check_val("s4_to_early", 64'(bus.err_timeout), 64'd0);
                check_val("s4_busy_early", 64'(bus.busy), 64'd1);
            end
        end
        check_val("s4_to_pulse", 64'(bus.err_timeout), 64'd1);
        check_val("s4_busy_after", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check_val("s4_to_width", 64'(bus.err_timeout), 64'd0);
        check_val("s4_to_cnt", 64'(n_to - t0), 64'd1);
        check_val("s4_ready_cnt", 64'(n_ready - r0), 64'd0);
        check_state("s4");
        send_frame(32'h5678_1234, 1'b0);
        idle(3);
        check_state("s4_next");

        // reset in the middle of a frame
        send_byte(8'hA5);
        send_byte(8'h34);
        send_byte(8'h12);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_bank = '0;
        exp_fc   = '0;
        check_state("s5_rst");
        send_frame(32'h5678_1234, 1'b0);
        idle(3);
        check_state("s5");

        // back-to-back frames
        r0 = n_ready;
        send_frame(32'h1122_3344, 1'b0);
        send_frame(32'hAABB_CCDD, 1'b0);
        idle(3);
        check_val("b2b_ready_cnt", 64'(n_ready - r0), 64'd2);
        check_state("b2b");

`ifndef IA_CHECKSUM_EN
        // trailing byte after a checksum-less commit is ignored in IDLE
        r0 = n_ready;
        send_frame(32'h5678_1234, 1'b0);
        send_byte(8'h08);
        idle(3);
        check_val("s6_ready_cnt", 64'(n_ready - r0), 64'd1);
        check_val("s6_cks_zero", 64'(n_cks), 64'd0);
        check_state("s6");
`endif

        check_val("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
